// File: rtl/mesh_link_pipe.sv
// mesh_link_pipe
// ----------------------------------------------------------------------------
// Multi-link, credit-based inter-router link stage. Each link gets LINK_STAGES
// register slices on the forward flit path {data, dest, is_tail, send} and the
// same number on the backward credit path. LINK_STAGES = 0 is a plain wire.
// Each link also carries a protocol monitor on the upstream side:
//   - a credit counter (pool = FLIT_BUFFER_DEPTH) fed by send_in / credit_out,
//   - a packet framing FSM (IDLE / IN_PKT) fed by send_in,
//   - sticky error flags cleared by err_clear.
// The monitor never alters the datapath outputs.
//
// Handshake: send_in / send_out are pure valid strobes with no ready; the
// upstream router may only send while it holds a credit, and credit_in /
// credit_out are single-cycle strobes each returning one buffer slot.
//
// Optional feature (macro MESH_LINK_STATS_EN): adds flit_count / pkt_count,
// 32-bit saturating per-link counters of downstream traffic.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   data_in/dest_in/is_tail_in/send_in   flit from upstream router
//   data_out/dest_out/is_tail_out/send_out  flit to downstream router
//   credit_in                  credit from downstream router
//   credit_out                 delayed credit to upstream router
//   err_clear                  synchronous clear of all sticky flags
//   credit_ovf_err             send seen with zero credits
//   credit_unf_err             credit returned with pool already full
//   framing_err                destination changed inside a packet
//   flit_count, pkt_count      (MESH_LINK_STATS_EN only) traffic counters
//   dbg_pkt_state              per-link framing FSM state (1 = IN_PKT)
//   dbg_credit_cnt             per-link credit counter value
// ----------------------------------------------------------------------------
module mesh_link_pipe #(
  parameter int NUM_LINKS         = 4,
  parameter int FLIT_WIDTH        = 128,
  parameter int DEST_WIDTH        = 4,
  parameter int LINK_STAGES       = 2,
  parameter int FLIT_BUFFER_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [FLIT_WIDTH-1:0]   data_in     [NUM_LINKS],
  input  logic [DEST_WIDTH-1:0]   dest_in     [NUM_LINKS],
  input  logic [NUM_LINKS-1:0]    is_tail_in,
  input  logic [NUM_LINKS-1:0]    send_in,
  output logic [NUM_LINKS-1:0]    credit_out,
  output logic [FLIT_WIDTH-1:0]   data_out    [NUM_LINKS],
  output logic [DEST_WIDTH-1:0]   dest_out    [NUM_LINKS],
  output logic [NUM_LINKS-1:0]    is_tail_out,
  output logic [NUM_LINKS-1:0]    send_out,
  input  logic [NUM_LINKS-1:0]    credit_in,
  input  logic                    err_clear,
  output logic [NUM_LINKS-1:0]    credit_ovf_err,
  output logic [NUM_LINKS-1:0]    credit_unf_err,
  output logic [NUM_LINKS-1:0]    framing_err,
`ifdef MESH_LINK_STATS_EN
  output logic [31:0]             flit_count  [NUM_LINKS],
  output logic [31:0]             pkt_count   [NUM_LINKS],
`endif
  output logic [NUM_LINKS-1:0]    dbg_pkt_state,
  output logic [$clog2(FLIT_BUFFER_DEPTH+1)-1:0] dbg_credit_cnt [NUM_LINKS]
);

  localparam int CW = $clog2(FLIT_BUFFER_DEPTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FLIT_BUFFER_DEPTH);

  // --------------------------------------------------------------------------
  // Datapath: forward flit slices and backward credit slices
  // --------------------------------------------------------------------------
  if (LINK_STAGES == 0) begin : g_bypass
    assign data_out    = data_in;
    assign dest_out    = dest_in;
    assign is_tail_out = is_tail_in;
    assign send_out    = send_in;
    assign credit_out  = credit_in;
  end else begin : g_pipe
    typedef struct packed {
      logic [FLIT_WIDTH-1:0] data;
      logic [DEST_WIDTH-1:0] dest;
      logic                  tail;
      logic                  send;
    } flit_t;

    flit_t                fwd_q [LINK_STAGES][NUM_LINKS];
    flit_t                fwd_d [LINK_STAGES][NUM_LINKS];
    logic [NUM_LINKS-1:0] crd_q [LINK_STAGES];
    logic [NUM_LINKS-1:0] crd_d [LINK_STAGES];

    // Slices are unconditional: credits guarantee downstream space, so there
    // is never a reason to stall.
    always_comb begin
      for (int l = 0; l < NUM_LINKS; l++) begin
        fwd_d[0][l] = '{data: data_in[l], dest: dest_in[l],
                        tail: is_tail_in[l], send: send_in[l]};
      end
      crd_d[0] = credit_in;
      for (int s = 1; s < LINK_STAGES; s++) begin
        fwd_d[s] = fwd_q[s-1];
        crd_d[s] = crd_q[s-1];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s < LINK_STAGES; s++) begin
          for (int l = 0; l < NUM_LINKS; l++) begin
            fwd_q[s][l] <= '0;
          end
          crd_q[s] <= '0;
        end
      end else begin
        fwd_q <= fwd_d;
        crd_q <= crd_d;
      end
    end

    always_comb begin
      for (int l = 0; l < NUM_LINKS; l++) begin
        data_out[l]    = fwd_q[LINK_STAGES-1][l].data;
        dest_out[l]    = fwd_q[LINK_STAGES-1][l].dest;
        is_tail_out[l] = fwd_q[LINK_STAGES-1][l].tail;
        send_out[l]    = fwd_q[LINK_STAGES-1][l].send;
      end
    end

    assign credit_out = crd_q[LINK_STAGES-1];
  end

  // --------------------------------------------------------------------------
  // Credit monitor (upstream view: send_in consumes, credit_out returns)
  // --------------------------------------------------------------------------
  logic [CW-1:0]        cnt_q [NUM_LINKS];
  logic [CW-1:0]        cnt_d [NUM_LINKS];
  logic [NUM_LINKS-1:0] ovf_set, unf_set;

  always_comb begin
    for (int l = 0; l < NUM_LINKS; l++) begin
      cnt_d[l]   = cnt_q[l];
      ovf_set[l] = 1'b0;
      unf_set[l] = 1'b0;
      // A send and a returning credit in the same cycle cancel out.
      if (send_in[l] && !credit_out[l]) begin
        if (cnt_q[l] == '0) ovf_set[l] = 1'b1;
        else                cnt_d[l]   = cnt_q[l] - CW'(1);
      end else if (credit_out[l] && !send_in[l]) begin
        if (cnt_q[l] == CNT_FULL) unf_set[l] = 1'b1;
        else                      cnt_d[l]   = cnt_q[l] + CW'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Framing FSM
  // --------------------------------------------------------------------------
  typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} pkt_state_e;

  pkt_state_e           state_q    [NUM_LINKS];
  pkt_state_e           state_d    [NUM_LINKS];
  logic [DEST_WIDTH-1:0] dest_lat_q [NUM_LINKS];
  logic [DEST_WIDTH-1:0] dest_lat_d [NUM_LINKS];
  logic [NUM_LINKS-1:0]  frm_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < NUM_LINKS; l++) state_q[l] <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    for (int l = 0; l < NUM_LINKS; l++) begin
      state_d[l]    = state_q[l];
      dest_lat_d[l] = dest_lat_q[l];
      frm_set[l]    = 1'b0;
      if (send_in[l]) begin
        case (state_q[l])
          IDLE: begin
            // Tail-only flits are complete packets and leave us in IDLE.
            if (!is_tail_in[l]) begin
              dest_lat_d[l] = dest_in[l];
              state_d[l]    = IN_PKT;
            end
          end
          IN_PKT: begin
            if (dest_in[l] != dest_lat_q[l]) frm_set[l] = 1'b1;
            if (is_tail_in[l])               state_d[l] = IDLE;
          end
          default: state_d[l] = IDLE;
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sticky flags: a new error in the clear cycle keeps the flag set.
  // --------------------------------------------------------------------------
  logic [NUM_LINKS-1:0] ovf_q, ovf_d, unf_q, unf_d, frm_q, frm_d;

  always_comb begin
    ovf_d = (err_clear ? '0 : ovf_q) | ovf_set;
    unf_d = (err_clear ? '0 : unf_q) | unf_set;
    frm_d = (err_clear ? '0 : frm_q) | frm_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < NUM_LINKS; l++) begin
        cnt_q[l]      <= CNT_FULL;
        dest_lat_q[l] <= '0;
      end
      ovf_q <= '0;
      unf_q <= '0;
      frm_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      dest_lat_q <= dest_lat_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      frm_q      <= frm_d;
    end
  end

  assign credit_ovf_err = ovf_q;
  assign credit_unf_err = unf_q;
  assign framing_err    = frm_q;
  assign dbg_credit_cnt = cnt_q;

  always_comb begin
    for (int l = 0; l < NUM_LINKS; l++) begin
      dbg_pkt_state[l] = (state_q[l] == IN_PKT);
    end
  end

`ifdef MESH_LINK_STATS_EN
  // --------------------------------------------------------------------------
  // Downstream traffic statistics (saturating)
  // --------------------------------------------------------------------------
  logic [31:0] flit_cnt_q [NUM_LINKS];
  logic [31:0] flit_cnt_d [NUM_LINKS];
  logic [31:0] pkt_cnt_q  [NUM_LINKS];
  logic [31:0] pkt_cnt_d  [NUM_LINKS];

  always_comb begin
    for (int l = 0; l < NUM_LINKS; l++) begin
      flit_cnt_d[l] = flit_cnt_q[l];
      pkt_cnt_d[l]  = pkt_cnt_q[l];
      if (err_clear) begin
        flit_cnt_d[l] = '0;
        pkt_cnt_d[l]  = '0;
      end else if (send_out[l]) begin
        if (flit_cnt_q[l] != '1) flit_cnt_d[l] = flit_cnt_q[l] + 32'd1;
        if (is_tail_out[l] && pkt_cnt_q[l] != '1) pkt_cnt_d[l] = pkt_cnt_q[l] + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < NUM_LINKS; l++) begin
        flit_cnt_q[l] <= '0;
        pkt_cnt_q[l]  <= '0;
      end
    end else begin
      flit_cnt_q <= flit_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  assign flit_count = flit_cnt_q;
  assign pkt_count  = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_mesh_link_pipe.sv
// tb_mesh_link_pipe
// Bench for mesh_link_pipe: one 4-link instance with LINK_STAGES=2 checked
// against a cycle-level reference model (input history queues, integer credit
// pools, packet-open flags), plus a 2-link LINK_STAGES=0 instance checked for
// same-cycle pass-through.
module tb_mesh_link_pipe;

  localparam int NL  = 4;
  localparam int LS  = 2;
  localparam int FBD = 4;
  localparam int FW  = 128;
  localparam int DW  = 4;
  localparam int CL  = 2;
  localparam int EW  = FW + DW + 3;  // {data, dest, tail, send, credit}

  typedef logic [EW-1:0] ent_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT signals ----------------
  logic [FW-1:0] data_in [NL];
  logic [FW-1:0] data_out [NL];
  logic [DW-1:0] dest_in [NL];
  logic [DW-1:0] dest_out [NL];
  logic [NL-1:0] is_tail_in, send_in, credit_in;
  logic [NL-1:0] is_tail_out, send_out, credit_out;
  logic [NL-1:0] ovf, unf, frm, dbg_state;
  logic [2:0]    dbg_cnt [NL];
  logic          err_clear;

  // ---------------- pass-through DUT signals ----------------
  logic [FW-1:0] c_data_in [CL];
  logic [FW-1:0] c_data_out [CL];
  logic [DW-1:0] c_dest_in [CL];
  logic [DW-1:0] c_dest_out [CL];
  logic [CL-1:0] c_tail_in, c_send_in, c_credit_in;
  logic [CL-1:0] c_tail_out, c_send_out, c_credit_out;
  logic [CL-1:0] c_ovf, c_unf, c_frm, c_dbg_state;
  logic [2:0]    c_dbg_cnt [CL];

`ifdef MESH_LINK_STATS_EN
  logic [31:0] flit_count [NL];
  logic [31:0] pkt_count [NL];
  logic [31:0] c_flit_count [CL];
  logic [31:0] c_pkt_count [CL];
`endif

  mesh_link_pipe #(
    .NUM_LINKS(NL), .FLIT_WIDTH(FW), .DEST_WIDTH(DW),
    .LINK_STAGES(LS), .FLIT_BUFFER_DEPTH(FBD)
  ) u_main (
    .clk(clk), .rst_n(rst_n),
    .data_in(data_in), .dest_in(dest_in), .is_tail_in(is_tail_in), .send_in(send_in),
    .credit_out(credit_out),
    .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out), .send_out(send_out),
    .credit_in(credit_in), .err_clear(err_clear),
    .credit_ovf_err(ovf), .credit_unf_err(unf), .framing_err(frm),
`ifdef MESH_LINK_STATS_EN
    .flit_count(flit_count), .pkt_count(pkt_count),
`endif
    .dbg_pkt_state(dbg_state), .dbg_credit_cnt(dbg_cnt)
  );

  mesh_link_pipe #(
    .NUM_LINKS(CL), .FLIT_WIDTH(FW), .DEST_WIDTH(DW),
    .LINK_STAGES(0), .FLIT_BUFFER_DEPTH(FBD)
  ) u_comb (
    .clk(clk), .rst_n(rst_n),
    .data_in(c_data_in), .dest_in(c_dest_in), .is_tail_in(c_tail_in), .send_in(c_send_in),
    .credit_out(c_credit_out),
    .data_out(c_data_out), .dest_out(c_dest_out), .is_tail_out(c_tail_out), .send_out(c_send_out),
    .credit_in(c_credit_in), .err_clear(err_clear),
    .credit_ovf_err(c_ovf), .credit_unf_err(c_unf), .framing_err(c_frm),
`ifdef MESH_LINK_STATS_EN
    .flit_count(c_flit_count), .pkt_count(c_pkt_count),
`endif
    .dbg_pkt_state(c_dbg_state), .dbg_credit_cnt(c_dbg_cnt)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  ent_t          hist [NL][$];   // inputs seen at the last LS edges
  int            cnt_m [NL];     // available credits
  logic [NL-1:0] ovf_m, unf_m, frm_m, inpkt_m;
  logic [DW-1:0] pdest_m [NL];

  task automatic model_reset();
    for (int l = 0; l < NL; l++) begin
      hist[l].delete();
      for (int s = 0; s < LS; s++) hist[l].push_back('0);
      cnt_m[l]   = FBD;
      pdest_m[l] = '0;
    end
    ovf_m = '0; unf_m = '0; frm_m = '0; inpkt_m = '0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    for (int l = 0; l < NL; l++) begin
      data_in[l] = '0;
      dest_in[l] = '0;
    end
    is_tail_in = '0; send_in = '0; credit_in = '0; err_clear = 1'b0;
    for (int l = 0; l < CL; l++) begin
      c_data_in[l] = '0;
      c_dest_in[l] = '0;
    end
    c_tail_in = '0; c_send_in = '0; c_credit_in = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock edge: the model consumes the inputs present at the edge, then
  // outputs are sampled 1 time unit later.
  task automatic step();
    logic [NL-1:0] crd_now;
    ent_t          e;
    for (int l = 0; l < NL; l++) begin
      e = hist[l][0];
      crd_now[l] = e[0];
    end
    @(posedge clk);
    for (int l = 0; l < NL; l++) begin
      logic no, nu, nf;
      no = 1'b0; nu = 1'b0; nf = 1'b0;
      if (send_in[l] && !crd_now[l]) begin
        if (cnt_m[l] == 0) no = 1'b1;
        else cnt_m[l] = cnt_m[l] - 1;
      end
      if (crd_now[l] && !send_in[l]) begin
        if (cnt_m[l] == FBD) nu = 1'b1;
        else cnt_m[l] = cnt_m[l] + 1;
      end
      if (send_in[l]) begin
        if (inpkt_m[l]) begin
          if (dest_in[l] != pdest_m[l]) nf = 1'b1;
          if (is_tail_in[l]) inpkt_m[l] = 1'b0;
        end else if (!is_tail_in[l]) begin
          inpkt_m[l] = 1'b1;
          pdest_m[l] = dest_in[l];
        end
      end
      ovf_m[l] = (err_clear ? 1'b0 : ovf_m[l]) | no;
      unf_m[l] = (err_clear ? 1'b0 : unf_m[l]) | nu;
      frm_m[l] = (err_clear ? 1'b0 : frm_m[l]) | nf;
      hist[l].push_back({data_in[l], dest_in[l], is_tail_in[l], send_in[l], credit_in[l]});
      void'(hist[l].pop_front());
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if (send_out !== '0 || credit_out !== '0 || is_tail_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs send=%b credit=%b tail=%b expected 0", send_out, credit_out, is_tail_out);
    end
    checks++;
    if (ovf !== '0 || unf !== '0 || frm !== '0) begin
      errors++;
      $display("FAIL reset_flags ovf=%b unf=%b frm=%b expected 0", ovf, unf, frm);
    end
    checks++;
    if (dbg_state !== '0) begin
      errors++;
      $display("FAIL reset_fsm state=%b expected 0", dbg_state);
    end
    for (int l = 0; l < NL; l++) begin
      checks++;
      if (dbg_cnt[l] !== 3'(FBD) || data_out[l] !== '0) begin
        errors++;
        $display("FAIL reset_link%0d cnt=%0d data=%h expected cnt=%0d data=0", l, dbg_cnt[l], data_out[l], FBD);
      end
    end
  endtask

  task automatic test_latency();
    send_in[0] = 1'b1; is_tail_in[0] = 1'b1; dest_in[0] = 4'd5; data_in[0] = 128'hA5;
    step();
    clear_inputs();
    checks++;
    if (send_out[0] !== 1'b0) begin
      errors++;
      $display("FAIL latency_early send_out=%b expected 0", send_out[0]);
    end
    step();
    checks++;
    if (send_out[0] !== 1'b1 || dest_out[0] !== 4'd5 || data_out[0] !== 128'hA5 || is_tail_out[0] !== 1'b1) begin
      errors++;
      $display("FAIL latency_flit send=%b dest=%0d data=%h tail=%b expected 1/5/a5/1",
               send_out[0], dest_out[0], data_out[0], is_tail_out[0]);
    end
    step();
    checks++;
    if (send_out[0] !== 1'b0) begin
      errors++;
      $display("FAIL latency_gone send_out=%b expected 0", send_out[0]);
    end
    credit_in[0] = 1'b1;
    step();
    credit_in[0] = 1'b0;
    checks++;
    if (credit_out[0] !== 1'b0) begin
      errors++;
      $display("FAIL credit_early credit_out=%b expected 0", credit_out[0]);
    end
    step();
    checks++;
    if (credit_out[0] !== 1'b1) begin
      errors++;
      $display("FAIL credit_delay credit_out=%b expected 1", credit_out[0]);
    end
    step();
    checks++;
    if (credit_out[0] !== 1'b0 || dbg_cnt[0] !== 3'd4 || unf[0] !== 1'b0) begin
      errors++;
      $display("FAIL credit_return credit_out=%b cnt=%0d unf=%b expected 0/4/0", credit_out[0], dbg_cnt[0], unf[0]);
    end
  endtask

  task automatic test_passthrough();
    for (int i = 0; i < 8; i++) begin
      for (int l = 0; l < CL; l++) begin
        c_data_in[l] = {$urandom, $urandom, $urandom, $urandom};
        c_dest_in[l] = DW'($urandom_range(0, 15));
      end
      c_tail_in = CL'($urandom_range(0, 3));
      c_send_in = CL'($urandom_range(0, 3));
      c_credit_in = CL'($urandom_range(0, 3));
      #1;
      checks++;
      if (c_send_out !== c_send_in || c_credit_out !== c_credit_in || c_tail_out !== c_tail_in ||
          c_data_out[1] !== c_data_in[1] || c_dest_out[0] !== c_dest_in[0]) begin
        errors++;
        $display("FAIL passthrough send=%b/%b credit=%b/%b tail=%b/%b dest0=%0d/%0d (got/expected)",
                 c_send_out, c_send_in, c_credit_out, c_credit_in, c_tail_out, c_tail_in,
                 c_dest_out[0], c_dest_in[0]);
      end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) begin
      send_in[0] = 1'b1; is_tail_in[0] = 1'b1; dest_in[0] = 4'd1;
      step();
      checks++;
      if (ovf[0] !== (i == 4) || dbg_cnt[0] !== 3'((i < 4) ? (3 - i) : 0)) begin
        errors++;
        $display("FAIL overflow_send%0d ovf=%b cnt=%0d expected %b/%0d", i, ovf[0], dbg_cnt[0],
                 (i == 4), (i < 4) ? (3 - i) : 0);
      end
    end
    clear_inputs();
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    checks++;
    if (ovf[0] !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear ovf=%b expected 0", ovf[0]);
    end
  endtask

  task automatic test_simultaneous();
    // Counter is 0 on link 0: a send paired with a returning credit is legal.
    credit_in[0] = 1'b1;
    step();
    credit_in[0] = 1'b0;
    step();
    send_in[0] = 1'b1; is_tail_in[0] = 1'b1;
    step();
    clear_inputs();
    checks++;
    if (ovf[0] !== 1'b0 || dbg_cnt[0] !== 3'd0) begin
      errors++;
      $display("FAIL simul_send_credit ovf=%b cnt=%0d expected 0/0", ovf[0], dbg_cnt[0]);
    end
    credit_in[0] = 1'b1;
    repeat (4) step();
    credit_in[0] = 1'b0;
    repeat (2) step();
    checks++;
    if (dbg_cnt[0] !== 3'd4 || unf[0] !== 1'b0) begin
      errors++;
      $display("FAIL refill cnt=%0d unf=%b expected 4/0", dbg_cnt[0], unf[0]);
    end
    credit_in[0] = 1'b1;
    step();
    credit_in[0] = 1'b0;
    repeat (2) step();
    checks++;
    if (unf[0] !== 1'b1 || dbg_cnt[0] !== 3'd4) begin
      errors++;
      $display("FAIL underflow unf=%b cnt=%0d expected 1/4", unf[0], dbg_cnt[0]);
    end
    // Another underflow landing in the err_clear cycle keeps the flag set.
    credit_in[0] = 1'b1;
    step();
    credit_in[0] = 1'b0;
    step();
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    checks++;
    if (unf[0] !== 1'b1) begin
      errors++;
      $display("FAIL clear_vs_new unf=%b expected 1", unf[0]);
    end
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    checks++;
    if (unf[0] !== 1'b0) begin
      errors++;
      $display("FAIL underflow_clear unf=%b expected 0", unf[0]);
    end
  endtask

  task automatic test_framing();
    logic [DW-1:0] dsts [5];
    logic          tls  [5];
    logic          exp_f [5];
    logic          exp_s [5];
    dsts = '{4'd3, 4'd3, 4'd3, 4'd3, 4'd7};
    tls  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_f = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_s = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      send_in[1] = 1'b1; credit_in[1] = 1'b1; dest_in[1] = dsts[i]; is_tail_in[1] = tls[i];
      step();
      checks++;
      if (frm[1] !== exp_f[i] || dbg_state[1] !== exp_s[i]) begin
        errors++;
        $display("FAIL framing_flit%0d frm=%b state=%b expected %b/%b", i, frm[1], dbg_state[1], exp_f[i], exp_s[i]);
      end
    end
    clear_inputs();
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    // Tail-only packet, then a new packet to a different destination.
    for (int i = 0; i < 3; i++) begin
      send_in[2] = 1'b1; credit_in[2] = 1'b1;
      dest_in[2] = (i == 0) ? 4'd5 : 4'd9;
      is_tail_in[2] = (i != 1);
      step();
      checks++;
      if (frm !== '0) begin
        errors++;
        $display("FAIL framing_single%0d frm=%b expected 0", i, frm);
      end
    end
    clear_inputs();
    repeat (3) step();
    checks++;
    if (unf !== '0 || ovf !== '0) begin
      errors++;
      $display("FAIL framing_credits ovf=%b unf=%b expected 0", ovf, unf);
    end
  endtask

  task automatic test_random();
    ent_t e;
    for (int c = 0; c < 400; c++) begin
      for (int l = 0; l < NL; l++) begin
        send_in[l]    = ($urandom_range(0, 99) < ((cnt_m[l] > 0) ? 50 : 5));
        data_in[l]    = {$urandom, $urandom, $urandom, $urandom};
        dest_in[l]    = DW'($urandom_range(0, 3));
        is_tail_in[l] = ($urandom_range(0, 99) < 40);
        credit_in[l]  = ($urandom_range(0, 99) < 30);
      end
      err_clear = ($urandom_range(0, 99) < 3);
      step();
      for (int l = 0; l < NL; l++) begin
        e = hist[l][0];
        checks++;
        if (send_out[l] !== e[1] || credit_out[l] !== e[0] || is_tail_out[l] !== e[2] ||
            dest_out[l] !== e[DW+2:3] || data_out[l] !== e[EW-1:DW+3]) begin
          errors++;
          $display("FAIL rand_datapath cyc=%0d link=%0d send=%b/%b credit=%b/%b tail=%b/%b dest=%0d/%0d (got/expected)",
                   c, l, send_out[l], e[1], credit_out[l], e[0], is_tail_out[l], e[2], dest_out[l], e[DW+2:3]);
        end
        checks++;
        if (dbg_cnt[l] !== 3'(cnt_m[l])) begin
          errors++;
          $display("FAIL rand_credit_cnt cyc=%0d link=%0d got=%0d expected=%0d", c, l, dbg_cnt[l], cnt_m[l]);
        end
      end
      checks++;
      if (ovf !== ovf_m || unf !== unf_m || frm !== frm_m || dbg_state !== inpkt_m) begin
        errors++;
        $display("FAIL rand_monitor cyc=%0d ovf=%b/%b unf=%b/%b frm=%b/%b state=%b/%b (got/expected)",
                 c, ovf, ovf_m, unf, unf_m, frm, frm_m, dbg_state, inpkt_m);
      end
    end
    clear_inputs();
  endtask

  task automatic test_mid_reset();
    send_in[0] = 1'b1; credit_in[0] = 1'b1; is_tail_in[0] = 1'b1; data_in[0] = 128'h1;
    step();
    data_in[0] = 128'h2;
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (send_out !== '0 || credit_out !== '0) begin
      errors++;
      $display("FAIL midreset_flush send=%b credit=%b expected 0", send_out, credit_out);
    end
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (send_out !== '0 || credit_out !== '0 || dbg_cnt[0] !== 3'(FBD) || dbg_cnt[3] !== 3'(FBD)) begin
        errors++;
        $display("FAIL midreset_after%0d send=%b credit=%b cnt0=%0d cnt3=%0d expected 0/0/%0d/%0d",
                 i, send_out, credit_out, dbg_cnt[0], dbg_cnt[3], FBD, FBD);
      end
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- sequence + report ----------------
  initial begin
    clear_inputs();
    model_reset();
    test_reset();
    test_latency();
    test_passthrough();
    test_overflow();
    test_simultaneous();
    test_framing();
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
